// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage for an RV32I 5-stage pipeline.
// Owns the PC, drives the instruction memory read port, captures the
// returned word into the IF/ID register and hands it to decode with a
// valid/ready handshake. EX-stage redirects flush IF/ID; a redirect to a
// target that is not word aligned parks the stage in TRAP until an aligned
// redirect arrives.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        IdReady,
  output logic        IMemEN,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  output logic        IfIdValid,
  output logic [31:0] IfIdInstr,
  output logic [31:0] IfIdPC,
  output logic [31:0] IfIdPCPlus4,
  output logic        FetchMisalign
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;

  // Next sequential fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  // A fetch target must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

  // The memory port presents the PC directly; fetches are only enabled in RUN.
  assign IMemAddr = pc;
  assign IMemEN   = (state == RUN);

  // PC, fetch state machine and IF/ID register, all updated together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      IfIdValid     <= 1'b0;
      IfIdInstr     <= NOP_INSTR;
      IfIdPC        <= 32'h0000_0000;
      IfIdPCPlus4   <= 32'h0000_0000;
      FetchMisalign <= 1'b0;
    end else begin
      unique case (state)
        // One idle cycle lets the memory image settle; redirects are ignored.
        BOOT: begin
          state <= RUN;
        end

        RUN: begin
          if (Redirect) begin
            // A redirect always wins, even over a stalled decode stage.
            pc        <= RedirectTarget;
            IfIdValid <= 1'b0;
            IfIdInstr <= NOP_INSTR;
            if (is_misaligned(RedirectTarget)) begin
              FetchMisalign <= 1'b1;
              state         <= TRAP;
            end
          end else if (IfIdValid && !IdReady) begin
            // Decode is stalled on a real instruction: hold everything.
            pc <= pc;
          end else begin
            IfIdInstr   <= IMemData;
            IfIdPC      <= pc;
            IfIdPCPlus4 <= pc_inc(pc);
            IfIdValid   <= 1'b1;
            pc          <= pc_inc(pc);
          end
        end

        TRAP: begin
          // Only a redirect can leave TRAP; a further bad target stays here.
          IfIdValid <= 1'b0;
          if (Redirect) begin
            pc <= RedirectTarget;
            if (!is_misaligned(RedirectTarget)) begin
              FetchMisalign <= 1'b0;
              state         <= RUN;
            end
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// traffic, all checked against a behavioural model of the fetch stage.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_n2 = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] target = 32'h0;
  logic        id_ready = 1'b1;

  logic        en1, valid1, mis1;
  logic [31:0] addr1, data1, instr1, pc1, p41;
  logic        en2, valid2, mis2;
  logic [31:0] addr2, data2, instr2, pc2, p42;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model state
  logic        m_boot, m_trap, m_valid, m_mis;
  logic [31:0] m_pc, m_instr, m_ifpc, m_p4;

  always #5 clk = ~clk;

  // Memory image: word i holds i+1.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  assign data1 = mem_word(addr1);
  assign data2 = mem_word(addr2);

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .Redirect(redirect), .RedirectTarget(target),
    .IdReady(id_ready), .IMemEN(en1), .IMemAddr(addr1), .IMemData(data1),
    .IfIdValid(valid1), .IfIdInstr(instr1), .IfIdPC(pc1), .IfIdPCPlus4(p41),
    .FetchMisalign(mis1)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n2), .Redirect(redirect), .RedirectTarget(target),
    .IdReady(id_ready), .IMemEN(en2), .IMemAddr(addr2), .IMemData(data2),
    .IfIdValid(valid2), .IfIdInstr(instr2), .IfIdPC(pc2), .IfIdPCPlus4(p42),
    .FetchMisalign(mis2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the behavioural rules for one rising edge using the current inputs.
  task automatic model_edge();
    if (!rst_n) begin
      m_boot = 1'b1; m_trap = 1'b0; m_pc = 32'h0; m_valid = 1'b0;
      m_instr = 32'h13; m_ifpc = 32'h0; m_p4 = 32'h0; m_mis = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_trap) begin
      if (redirect) begin
        m_pc = target;
        if (target % 4 == 0) begin
          m_trap = 1'b0;
          m_mis  = 1'b0;
        end
      end
    end else if (redirect) begin
      m_pc = target; m_valid = 1'b0; m_instr = 32'h13;
      if (target % 4 != 0) begin
        m_trap = 1'b1;
        m_mis  = 1'b1;
      end
    end else if (!(m_valid && !id_ready)) begin
      m_instr = mem_word(m_pc); m_ifpc = m_pc; m_p4 = m_pc + 32'd4;
      m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_model();
    chk("en",    {31'b0, en1},    {31'b0, !m_boot && !m_trap});
    chk("addr",  addr1,           m_pc);
    chk("valid", {31'b0, valid1}, {31'b0, m_valid});
    chk("instr", instr1,          m_instr);
    chk("ifpc",  pc1,             m_ifpc);
    chk("pc4",   p41,             m_p4);
    chk("mis",   {31'b0, mis1},   {31'b0, m_mis});
  endtask

  task automatic step(input logic r, input logic rd, input logic [31:0] tgt, input logic rdy);
    rst_n    = r;
    redirect = rd;
    target   = tgt;
    id_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    logic        r, rd, rdy;
    logic [31:0] tgt;

    // 1: reset, BOOT cycle, then sequential fetch
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_rst_valid", {31'b0, valid1}, 32'd0);
    chk("t1_rst_instr", instr1, 32'h13);
    chk("t1_boot_en", {31'b0, en1}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t1_run_en", {31'b0, en1}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("t1_pc", pc1, 32'(i * 4));
      chk("t1_instr", instr1, 32'(i + 1));
    end

    // wrap instance reset state while held in reset
    chk("t5_rst_valid", {31'b0, valid2}, 32'd0);
    chk("t5_rst_en", {31'b0, en2}, 32'd0);
    chk("t5_rst_addr", addr2, 32'hFFFF_FFF8);

    // 2: stall three cycles at IfIdPC=8
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("t2_hold_pc", pc1, 32'h8);
      chk("t2_hold_addr", addr1, 32'hC);
      chk("t2_hold_instr", instr1, 32'h3);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t2_resume_pc", pc1, 32'hC);

    // 3: redirect during a stall
    step(1'b1, 1'b1, 32'h40, 1'b0);
    chk("t3_flush_valid", {31'b0, valid1}, 32'd0);
    chk("t3_flush_instr", instr1, 32'h13);
    chk("t3_flush_addr", addr1, 32'h40);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t3_target_pc", pc1, 32'h40);
    chk("t3_target_instr", instr1, 32'h11);

    // 4: misaligned redirect then aligned recovery
    step(1'b1, 1'b1, 32'h42, 1'b1);
    chk("t4_mis", {31'b0, mis1}, 32'd1);
    chk("t4_en", {31'b0, en1}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t4_trap_valid", {31'b0, valid1}, 32'd0);
    chk("t4_trap_addr", addr1, 32'h42);
    step(1'b1, 1'b1, 32'h80, 1'b1);
    chk("t4_clear_mis", {31'b0, mis1}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t4_target_pc", pc1, 32'h80);

    // 5: PC wrap on the second instance
    rst_n2 = 1'b1;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t5_run_addr", addr2, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t5_pc0", pc2, 32'hFFFF_FFF8);
    chk("t5_p40", p42, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t5_pc1", pc2, 32'hFFFF_FFFC);
    chk("t5_p41", p42, 32'h0000_0000);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t5_pc2", pc2, 32'h0000_0000);
    chk("t5_instr2", instr2, 32'h1);

    // 6: reset coincident with redirect and stall; redirect during BOOT ignored
    step(1'b0, 1'b1, 32'h100, 1'b0);
    chk("t6_rst_valid", {31'b0, valid1}, 32'd0);
    chk("t6_rst_addr", addr1, 32'h0);
    chk("t6_rst_pc", pc1, 32'h0);
    step(1'b1, 1'b1, 32'h100, 1'b1);
    chk("t6_boot_addr", addr1, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t6_restart_pc", pc1, 32'h0);
    chk("t6_restart_instr", instr1, 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) != 0);
      rd  = ($urandom_range(0, 9) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      rdy = ($urandom_range(0, 9) < 7);
      step(r, rd, tgt, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
